pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage for the MIPS datapath. Holds the PC, drives the instruction-memory request handshake, delivers each fetched instruction with its PC and PC+4, and selects the next PC from sequential, branch, jump and jump-register sources. It sits directly upstream of the 32-bit adder/ALU datapath: its `instr_pc_plus4` and branch-target sums feed the decode/execute stage.

---
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and instruction-fetch stage with next-PC select.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_target;
  logic        w_misaligned;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instr_pc_plus4;
  logic        r_addr_error;

  // Redirect target is formed from the delivered instruction's PC+4.
  always_comb begin
    w_pc_target  = r_instr_pc_plus4;
    w_misaligned = 1'b0;
    if (jump_reg) begin
      w_pc_target  = {jump_reg_addr[31:2], 2'b00};
      w_misaligned = |jump_reg_addr[1:0];
    end else if (jump) begin
      w_pc_target = {r_instr_pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      w_pc_target = r_instr_pc_plus4 + (branch_offset << 2);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = REQ;
      REQ:     if (imem_ready) w_next_state = DELIVER;
      DELIVER: if (!stall) w_next_state = REQ;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_pc             <= RESET_PC;
      r_imem_req       <= 1'b0;
      r_instr_valid    <= 1'b0;
      r_instr          <= 32'h0;
      r_instr_pc       <= 32'h0;
      r_instr_pc_plus4 <= 32'h0;
      r_addr_error     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_imem_req    <= (w_next_state == REQ);
      r_instr_valid <= (w_next_state == DELIVER);
      r_addr_error  <= 1'b0;
      if (r_state == REQ && imem_ready) begin
        r_instr          <= imem_rdata;
        r_instr_pc       <= r_pc;
        r_instr_pc_plus4 <= r_pc + 32'd4;
      end
      if (r_state == DELIVER && !stall) begin
        r_pc         <= w_pc_target;
        r_addr_error <= w_misaligned;
      end
    end
  end

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc_plus4;
  assign addr_error     = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Randomized self-checking bench for pc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jump_reg = 1'b0;
  logic [31:0] jump_reg_addr = 32'h0;
  logic        imem_ready = 1'b0;

  logic        imem_req, instr_valid, addr_error;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, instr_pc_plus4;
  logic        w_imem_req, w_instr_valid, w_addr_error;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_instr_pc, w_instr_pc_plus4;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  pc_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .addr_error(addr_error)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr), .imem_req(w_imem_req),
    .imem_addr(w_imem_addr), .imem_ready(imem_ready), .imem_rdata(w_imem_rdata),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_pc_plus4(w_instr_pc_plus4), .addr_error(w_addr_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect;
    branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    branch_offset = 32'h0; jump_index = 26'h0; jump_reg_addr = 32'h0;
  endtask

  // Fetches one instruction from the REQ cycle through the release of DELIVER,
  // then advances the reference PC using the architectural next-PC rules.
  task automatic run_instr(input int waits, input int stalls,
                           input logic br, input logic [31:0] off,
                           input logic j, input logic [25:0] idx,
                           input logic jr, input logic [31:0] jra);
    logic [31:0] plus4, npc;
    logic        err;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      fails++;
      $display("FAIL req_addr: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, m_pc);
    end
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      tick;
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || addr_error !== 1'b0) begin
        fails++;
        $display("FAIL wait_hold: got req=%b addr=%h valid=%b err=%b want 1 %h 0 0",
                 imem_req, imem_addr, instr_valid, addr_error, m_pc);
      end
    end
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    plus4 = m_pc + 32'd4;
    for (int s = 0; s <= stalls; s++) begin
      tests++;
      if (instr_valid !== 1'b1 || instr !== mem_word(m_pc) || instr_pc !== m_pc ||
          instr_pc_plus4 !== plus4 || imem_req !== 1'b0 || addr_error !== 1'b0) begin
        fails++;
        $display("FAIL deliver: got v=%b i=%h pc=%h p4=%h req=%b err=%b want 1 %h %h %h 0 0",
                 instr_valid, instr, instr_pc, instr_pc_plus4, imem_req, addr_error,
                 mem_word(m_pc), m_pc, plus4);
      end
      if (s < stalls) begin
        stall = 1'b1;
        branch_taken = 1'($urandom); jump = 1'($urandom); jump_reg = 1'($urandom);
        branch_offset = $urandom; jump_index = 26'($urandom); jump_reg_addr = $urandom | 32'h1;
        imem_ready = 1'($urandom);
        tick;
        imem_ready = 1'b0;
      end
    end
    stall = 1'b0;
    branch_taken = br; branch_offset = off; jump = j; jump_index = idx;
    jump_reg = jr; jump_reg_addr = jra;
    tick;
    clear_redirect;
    err = 1'b0;
    if (jr) begin
      npc = jra - (jra % 4);
      err = (jra % 4) != 0;
    end else if (j) begin
      npc = (plus4 & 32'hF000_0000) + {4'h0, idx, 2'b00};
    end else if (br) begin
      npc = plus4 + off * 32'd4;
    end else begin
      npc = plus4;
    end
    m_pc = npc;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || addr_error !== err) begin
      fails++;
      $display("FAIL next_pc: got req=%b addr=%h valid=%b err=%b want 1 %h 0 %b",
               imem_req, imem_addr, instr_valid, addr_error, m_pc, err);
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    clear_redirect;
    stall = 1'b0;
    imem_ready = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    apply_reset;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0000 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h0 || addr_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got req=%b addr=%h v=%b i=%h pc=%h p4=%h err=%b want all zero, addr 00400000",
               imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4, addr_error);
    end
    reset = 1'b0;
    tick;
    m_pc = 32'h0040_0000;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      fails++;
      $display("FAIL first_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, m_pc);
    end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 3; k++) run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (imem_addr !== 32'h0040_000C) begin
      fails++;
      $display("FAIL seq_addr: got %h want 0040000c", imem_addr);
    end
  endtask

  task automatic test_jump_branch;
    run_instr(0, 0, 0, 0, 1, 26'h40, 0, 0);
    run_instr(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    tests++;
    if (imem_addr !== 32'h0000_00FC) begin
      fails++;
      $display("FAIL branch_back: got %h want 000000fc", imem_addr);
    end
    run_instr(1, 0, 1, 32'h0000_0010, 1, 26'h40, 0, 0);
    tests++;
    if (imem_addr !== 32'h0000_0100) begin
      fails++;
      $display("FAIL jump_wins: got %h want 00000100", imem_addr);
    end
  endtask

  task automatic test_jr;
    run_instr(0, 0, 1, 32'h4, 1, 26'h123, 1, 32'h0000_2003);
    tests++;
    if (imem_addr !== 32'h0000_2000 || addr_error !== 1'b1) begin
      fails++;
      $display("FAIL jr_target: got addr=%h err=%b want 00002000 1", imem_addr, addr_error);
    end
    run_instr(2, 0, 0, 0, 0, 0, 1, 32'h0000_3000);
  endtask

  task automatic test_stall;
    run_instr(0, 3, 1, 32'h0000_0004, 0, 0, 0, 0);
    run_instr(1, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), {{16{1'($urandom)}}, 16'($urandom)}, 1'($urandom),
                26'($urandom), ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  task automatic test_wrap;
    apply_reset;
    reset = 1'b0;
    tick;
    tests++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_req: got req=%b addr=%h want 1 fffffffc", w_imem_req, w_imem_addr);
    end
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    tests++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr_pc_plus4 !== 32'h0 ||
        w_instr !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL wrap_deliver: got v=%b pc=%h p4=%h i=%h want 1 fffffffc 00000000 %h",
               w_instr_valid, w_instr_pc, w_instr_pc_plus4, w_instr, mem_word(32'hFFFF_FFFC));
    end
    tick;
    tests++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_next: got req=%b addr=%h want 1 00000000", w_imem_req, w_imem_addr);
    end
  endtask

  task automatic test_reset_mid_req;
    apply_reset;
    reset = 1'b0;
    tick;
    m_pc = 32'h0040_0000;
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) tick;
    tests++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0040_0004) begin
      fails++;
      $display("FAIL long_wait: got req=%b v=%b addr=%h want 1 0 00400004", imem_req, instr_valid, imem_addr);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL restart: got req=%b addr=%h v=%b want 1 00400000 0", imem_req, imem_addr, instr_valid);
    end
    tick;
    tests++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL discard: got v=%b i=%h req=%b want 0 00000000 1", instr_valid, instr, imem_req);
    end
    m_pc = 32'h0040_0000;
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_jump_branch;
    test_jr;
    test_stall;
    test_random;
    test_wrap;
    test_reset_mid_req;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
